// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, 3-sample majority voting,
// LSB-first deserialisation, parity-checker handshake and frame qualification.
module uart_rx_frame_ctrl #(
  parameter int data_width = 8
) (
  input  logic                  rx_clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  parity_enable,
  input  logic                  parity_error,
  output logic                  sampled_bit,
  output logic [data_width-1:0] p_data,
  output logic                  parity_check_enable,
  output logic                  data_valid,
  output logic                  framing_error,
  output logic                  start_glitch,
  output logic                  busy
);

  localparam int BIT_W = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(data_width - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q, state_d;
  logic [4:0]            edge_cnt_q, edge_cnt_d;
  logic [4:0]            p_last_q, p_last_d;     // latched P-1 for the frame
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  par_en_q, par_en_d;
  logic [2:0]            samples_q, samples_d;
  logic                  sampled_q, sampled_d;
  logic [data_width-1:0] p_data_q, p_data_d;
  logic                  busy_q, busy_d;

  logic [4:0] mid;
  logic       last_edge;
  logic       majority;

  assign mid       = {1'b0, p_last_q[4:1]} + 5'd1;
  assign last_edge = (edge_cnt_q == p_last_q);
  assign majority  = (samples_q[0] & samples_q[1]) | (samples_q[0] & samples_q[2]) |
                     (samples_q[1] & samples_q[2]);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      p_last_q   <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      samples_q  <= '0;
      sampled_q  <= 1'b0;
      p_data_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      p_last_q   <= p_last_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      samples_q  <= samples_d;
      sampled_q  <= sampled_d;
      p_data_q   <= p_data_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    p_last_d   = p_last_q;
    bit_cnt_d  = bit_cnt_q;
    par_en_d   = par_en_q;
    samples_d  = samples_q;
    sampled_d  = sampled_q;
    p_data_d   = p_data_q;

    if (state_q == IDLE) begin
      if (!rx_in) begin
        state_d    = START;
        edge_cnt_d = 5'd1;
        case (prescale)
          6'd16:   p_last_d = 5'd15;
          6'd32:   p_last_d = 5'd31;
          default: p_last_d = 5'd7;
        endcase
      end
    end else begin
      edge_cnt_d = last_edge ? 5'd0 : edge_cnt_q + 5'd1;

      if (edge_cnt_q == mid - 5'd1) samples_d[0] = rx_in;
      if (edge_cnt_q == mid)        samples_d[1] = rx_in;
      if (edge_cnt_q == mid + 5'd1) samples_d[2] = rx_in;
      if (edge_cnt_q == mid + 5'd2) sampled_d    = majority;

      if (last_edge) begin
        case (state_q)
          START: begin
            state_d   = sampled_q ? IDLE : DATA;
            bit_cnt_d = '0;
          end
          DATA: begin
            p_data_d  = {sampled_q, p_data_q[data_width-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              par_en_d = parity_enable;
              state_d  = parity_enable ? PARITY : STOP;
            end
          end
          PARITY:  state_d = STOP;
          default: state_d = IDLE;
        endcase
      end
    end

    busy_d = (state_d != IDLE);
  end

  // Pulses are decoded from registered state only; parity_error is the
  // checker's own registered result.
  always_comb begin
    sampled_bit         = sampled_q;
    p_data              = p_data_q;
    busy                = busy_q;
    start_glitch        = (state_q == START)  && last_edge && sampled_q;
    parity_check_enable = (state_q == PARITY) && last_edge;
    framing_error       = (state_q == STOP)   && last_edge && !sampled_q;
    data_valid          = (state_q == STOP)   && last_edge && sampled_q &&
                          !(par_en_q && parity_error);
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: drives whole serial frames bit by bit
// and counts the controller's output pulses from a negedge monitor.
module tb_uart_rx_frame_ctrl;

  logic       rx_clk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rx_in  = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       parity_enable = 1'b0;
  logic       parity_error;
  logic       sampled_bit;
  logic [7:0] p_data;
  logic       parity_check_enable, data_valid, framing_error, start_glitch, busy;

  logic       inject_perr = 1'b0;
  int         n_checks = 0;
  int         n_fail   = 0;

  int         dv_total = 0, fe_total = 0, sg_total = 0, pce_total = 0;
  logic [7:0] dv_data[$];

  uart_rx_frame_ctrl #(.data_width(8)) dut (
    .rx_clk(rx_clk), .rst_n(rst_n), .rx_in(rx_in), .prescale(prescale),
    .parity_enable(parity_enable), .parity_error(parity_error),
    .sampled_bit(sampled_bit), .p_data(p_data),
    .parity_check_enable(parity_check_enable), .data_valid(data_valid),
    .framing_error(framing_error), .start_glitch(start_glitch), .busy(busy)
  );

  always #5 rx_clk = ~rx_clk;

  // Sticky parity checker stand-in: registered, set only when told to fail.
  always @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n)                                  parity_error <= 1'b0;
    else if (!inject_perr)                       parity_error <= 1'b0;
    else if (parity_check_enable)                parity_error <= 1'b1;
  end

  always @(negedge rx_clk) begin
    if (rst_n) begin
      if (data_valid) begin
        dv_total++;
        dv_data.push_back(p_data);
      end
      if (framing_error)       fe_total++;
      if (start_glitch)        sg_total++;
      if (parity_check_enable) pce_total++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Value set here is seen by the DUT at bit-relative edge c.
  task automatic drive_bit(input int p, input logic v, input int glitch_edge);
    for (int c = 0; c < p; c++) begin
      rx_in = (c == glitch_edge) ? ~v : v;
      @(posedge rx_clk); #1;
    end
  endtask

  task automatic send_frame(input int p, input logic [7:0] d, input logic with_par,
                            input logic stop, input int glitch_edge);
    drive_bit(p, 1'b0, -1);
    for (int i = 0; i < 8; i++) drive_bit(p, d[i], glitch_edge);
    if (with_par) drive_bit(p, ^d, -1);
    drive_bit(p, stop, -1);
    rx_in = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({sampled_bit, p_data, parity_check_enable, data_valid, framing_error,
         start_glitch, busy} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b p_data=%h sb=%b want all zero",
               busy, p_data, sampled_bit);
    end
    @(posedge rx_clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge rx_clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_parity_frame;
    int dv0, pce0, fe0;
    dv0 = dv_total; pce0 = pce_total; fe0 = fe_total;
    prescale = 6'd8; parity_enable = 1'b1;
    send_frame(8, 8'hA5, 1'b1, 1'b1, -1);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL t1_busy_after: got %b want 0", busy);
    end
    n_checks++;
    if (dv_total - dv0 != 1) begin
      n_fail++; $display("FAIL t1_data_valid: got %0d pulses want 1", dv_total - dv0);
    end
    n_checks++;
    if (p_data !== 8'hA5) begin
      n_fail++; $display("FAIL t1_p_data: got %h want a5", p_data);
    end
    n_checks++;
    if (pce_total - pce0 != 1) begin
      n_fail++; $display("FAIL t1_pce: got %0d pulses want 1", pce_total - pce0);
    end
    n_checks++;
    if (fe_total != fe0) begin
      n_fail++; $display("FAIL t1_no_fe: got %0d pulses want 0", fe_total - fe0);
    end
  endtask

  task automatic test_start_glitch;
    int dv0, sg0;
    dv0 = dv_total; sg0 = sg_total;
    prescale = 6'd8;
    rx_in = 1'b0;
    repeat (3) @(posedge rx_clk);
    #1; rx_in = 1'b1;
    repeat (12) @(posedge rx_clk);
    #1;
    n_checks++;
    if (sg_total - sg0 != 1) begin
      n_fail++; $display("FAIL t2_start_glitch: got %0d pulses want 1", sg_total - sg0);
    end
    n_checks++;
    if (dv_total != dv0) begin
      n_fail++; $display("FAIL t2_no_dv: got %0d pulses want 0", dv_total - dv0);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL t2_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_framing_error;
    int dv0, fe0, pce0;
    dv0 = dv_total; fe0 = fe_total; pce0 = pce_total;
    prescale = 6'd16; parity_enable = 1'b0;
    send_frame(16, 8'h3C, 1'b0, 1'b0, -1);
    repeat (2) @(posedge rx_clk);
    #1;
    n_checks++;
    if (fe_total - fe0 != 1) begin
      n_fail++; $display("FAIL t3_framing: got %0d pulses want 1", fe_total - fe0);
    end
    n_checks++;
    if (dv_total != dv0) begin
      n_fail++; $display("FAIL t3_no_dv: got %0d pulses want 0", dv_total - dv0);
    end
    n_checks++;
    if (pce_total != pce0) begin
      n_fail++; $display("FAIL t3_no_pce: got %0d pulses want 0", pce_total - pce0);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL t3_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_parity_error;
    int dv0, fe0, pce0;
    dv0 = dv_total; fe0 = fe_total; pce0 = pce_total;
    prescale = 6'd8; parity_enable = 1'b1; inject_perr = 1'b1;
    send_frame(8, 8'h6E, 1'b1, 1'b1, -1);
    n_checks++;
    if (dv_total != dv0) begin
      n_fail++; $display("FAIL t4_dropped_dv: got %0d pulses want 0", dv_total - dv0);
    end
    n_checks++;
    if (fe_total != fe0) begin
      n_fail++; $display("FAIL t4_no_fe: got %0d pulses want 0", fe_total - fe0);
    end
    n_checks++;
    if (pce_total - pce0 != 1) begin
      n_fail++; $display("FAIL t4_pce: got %0d pulses want 1", pce_total - pce0);
    end
    inject_perr = 1'b0;
    repeat (2) @(posedge rx_clk);
    #1;
    send_frame(8, 8'h01, 1'b1, 1'b1, -1);
    n_checks++;
    if (dv_total - dv0 != 1) begin
      n_fail++; $display("FAIL t4_good_dv: got %0d pulses want 1", dv_total - dv0);
    end
    n_checks++;
    if (p_data !== 8'h01) begin
      n_fail++; $display("FAIL t4_p_data: got %h want 01", p_data);
    end
  endtask

  task automatic test_back_to_back;
    int dv0;
    logic [7:0] got0, got1;
    dv0 = dv_data.size();
    prescale = 6'd32; parity_enable = 1'b1;
    send_frame(32, 8'h55, 1'b1, 1'b1, 16);
    send_frame(32, 8'hF0, 1'b1, 1'b1, 15);
    n_checks++;
    if (dv_data.size() - dv0 != 2) begin
      n_fail++; $display("FAIL t5_dv_count: got %0d pulses want 2", dv_data.size() - dv0);
    end else begin
      got0 = dv_data[dv0];
      got1 = dv_data[dv0 + 1];
      n_checks++;
      if (got0 !== 8'h55) begin
        n_fail++; $display("FAIL t5_frame0: got %h want 55", got0);
      end
      n_checks++;
      if (got1 !== 8'hF0) begin
        n_fail++; $display("FAIL t5_frame1: got %h want f0", got1);
      end
    end
  endtask

  task automatic test_prescale_default;
    int dv0;
    dv0 = dv_total;
    prescale = 6'd12; parity_enable = 1'b0;
    send_frame(8, 8'hC3, 1'b0, 1'b1, -1);
    n_checks++;
    if (dv_total - dv0 != 1 || p_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL t7_prescale_default: got %0d pulses p_data=%h want 1 pulse c3",
               dv_total - dv0, p_data);
    end
  endtask

  task automatic test_mid_frame_reset;
    logic [7:0] d;
    int dv0;
    d = 8'hFF;
    prescale = 6'd8; parity_enable = 1'b0;
    drive_bit(8, 1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(8, d[i], -1);
    repeat (4) begin
      rx_in = d[4];
      @(posedge rx_clk); #1;
    end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({sampled_bit, p_data, parity_check_enable, data_valid, framing_error,
         start_glitch, busy} !== 14'd0) begin
      n_fail++;
      $display("FAIL t6_reset_outputs: got busy=%b p_data=%h sb=%b want all zero",
               busy, p_data, sampled_bit);
    end
    rx_in = 1'b1;
    repeat (3) @(posedge rx_clk);
    #1; rst_n = 1'b1;
    repeat (3) @(posedge rx_clk);
    #1;
    dv0 = dv_total;
    send_frame(8, 8'h81, 1'b0, 1'b1, -1);
    n_checks++;
    if (dv_total - dv0 != 1 || p_data !== 8'h81) begin
      n_fail++;
      $display("FAIL t6_after_reset: got %0d pulses p_data=%h want 1 pulse 81",
               dv_total - dv0, p_data);
    end
  endtask

  initial begin
    test_reset();
    test_parity_frame();
    test_start_glitch();
    test_framing_error();
    test_parity_error();
    test_back_to_back();
    test_prescale_default();
    test_mid_frame_reset();
    repeat (2) @(posedge rx_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
